mips_fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the MIPS core; supersedes the bare PC register.

---
 rtl/mips_fetch_pkg.sv | 9 +
 rtl/fetch_queue.sv | 40 ++++
 rtl/mips_fetch_unit.sv | 75 +++++++
 tb/tb_mips_fetch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared types and constants for the instruction-fetch front end
package mips_fetch_pkg;
  typedef enum logic [1:0] {RUN, HALTING, HALTED} fetch_state_e;
  localparam int INST_BYTES = 4;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO with occupancy count and synchronous flush
module fetch_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk or posedge rst_b)
    if (rst_b) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= pop ? inc(rd_ptr) : rd_ptr;
      wr_ptr <= push ? inc(wr_ptr) : wr_ptr;
      count  <= count + CW'(push) - CW'(pop);
    end
  assign pop_data = mem[rd_ptr];
  a_no_overflow: assert property (@(posedge clk) disable iff (rst_b) !(push && !pop && count == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst_b) !(pop && count == '0));
endmodule

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: fetch PC, pipelined imem requests, prefetch queue, redirect and halt
module mips_fetch_unit import mips_fetch_pkg::*; #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = '0,
  parameter int              QDEPTH   = 4,
  parameter int              MAX_OUT  = 2
) (
  input  logic            clk,
  input  logic            rst_b,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  input  logic            halt_req,
  output logic            deq_valid,
  output logic [31:0]     deq_inst,
  output logic [XLEN-1:0] deq_pc,
  input  logic            deq_ready,
  output logic            halted
);
  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int PW = $clog2(MAX_OUT) + 1;
  fetch_state_e state;
  logic [XLEN-1:0] fetch_pc, rsp_pc;
  logic [CW-1:0] outstanding, drop_cnt, out_nxt, q_cnt, q_nxt;
  logic [PW-1:0] pc_cnt;
  logic [CW:0] reserved;
  logic redir, accept, q_push, q_pop;
  assign redir = redirect_valid && state != HALTED;
  // every live request must already own a queue slot when its word returns
  assign reserved = {1'b0, q_cnt} + {1'b0, outstanding} - {1'b0, drop_cnt};
  assign imem_req_valid = !rst_b && state == RUN && !redir && outstanding < CW'(MAX_OUT)
                          && reserved < (CW+1)'(QDEPTH);
  assign imem_req_addr = fetch_pc;
  assign accept = imem_req_valid && imem_req_ready;
  assign q_push = imem_rsp_valid && drop_cnt == '0 && !redir;
  assign deq_valid = q_cnt != '0 && !redir;
  assign q_pop = deq_valid && deq_ready;
  assign out_nxt = outstanding + CW'(accept) - CW'(imem_rsp_valid);
  assign q_nxt = redir ? '0 : q_cnt + CW'(q_push) - CW'(q_pop);
  assign halted = state == HALTED;
  always_ff @(posedge clk or posedge rst_b)
    if (rst_b) begin
      state       <= RUN;
      fetch_pc    <= PC_RESET;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= out_nxt;
      drop_cnt    <= redir ? out_nxt : drop_cnt - CW'(imem_rsp_valid && drop_cnt != '0);
      fetch_pc    <= redir ? {redirect_addr[XLEN-1:2], 2'b00}
                   : accept ? fetch_pc + XLEN'(INST_BYTES) : fetch_pc;
      state       <= halted ? HALTED
                   : (state == HALTING && out_nxt == '0 && q_nxt == '0) ? HALTED
                   : (state == RUN && halt_req) ? HALTING : state;
    end
  fetch_queue #(.WIDTH(XLEN + 32), .DEPTH(QDEPTH)) u_prefetch (
    .clk(clk), .rst_b(rst_b), .flush(redir), .push(q_push),
    .push_data({rsp_pc, imem_rsp_data}), .pop(q_pop),
    .pop_data({deq_pc, deq_inst}), .count(q_cnt)
  );
  // holds the PC of every outstanding request, stale ones included
  fetch_queue #(.WIDTH(XLEN), .DEPTH(MAX_OUT)) u_pc_fifo (
    .clk(clk), .rst_b(rst_b), .flush(1'b0), .push(accept),
    .push_data(fetch_pc), .pop(imem_rsp_valid),
    .pop_data(rsp_pc), .count(pc_cnt)
  );
  a_rsp_expected: assert property (@(posedge clk) disable iff (rst_b) !(imem_rsp_valid && outstanding == '0));
  a_drop_bound: assert property (@(posedge clk) disable iff (rst_b) drop_cnt <= outstanding);
  a_aligned: assert property (@(posedge clk) disable iff (rst_b) imem_req_addr[1:0] == 2'b00);
  a_pc_track: assert property (@(posedge clk) disable iff (rst_b) CW'(pc_cnt) == outstanding);
endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb_mips_fetch_unit: directed + random checks of the fetch unit against a queue-level model
module tb_mips_fetch_unit;
  localparam int QDEPTH = 4;
  localparam int MAX_OUT = 2;
  localparam logic [31:0] PC_RESET = 32'h0;
  logic clk, rst_b;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic redirect_valid, halt_req, deq_valid, deq_ready, halted;
  logic [31:0] redirect_addr, deq_inst, deq_pc;

  mips_fetch_unit #(.XLEN(32), .PC_RESET(PC_RESET), .QDEPTH(QDEPTH), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst_b(rst_b),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr), .halt_req(halt_req),
    .deq_valid(deq_valid), .deq_inst(deq_inst), .deq_pc(deq_pc), .deq_ready(deq_ready),
    .halted(halted)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit live; } req_t;
  req_t pend[$];
  logic [31:0] mq[$];
  logic [31:0] m_pc;
  int m_state;
  int cyc, lat, rsp_pct, errors, checks, halted_cyc;
  logic [31:0] acc_log[$], deq_log[$];
  int acc_cyc[$], deq_cyc[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (pend[i]) n += int'(pend[i].live);
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    acc_log.delete(); acc_cyc.delete(); deq_log.delete(); deq_cyc.delete();
    halted_cyc = -1;
  endtask

  task automatic do_reset();
    rst_b = 1;
    redirect_valid = 0;
    halt_req = 0;
    imem_rsp_valid = 0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 0);
    chk("rst_deq_valid", 32'(deq_valid), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_req_addr", imem_req_addr, PC_RESET);
    pend.delete(); mq.delete();
    m_pc = PC_RESET;
    m_state = 0;
    clear_logs();
    @(negedge clk);
    @(posedge clk);
    #1 rst_b = 0;
  endtask

  // one clock: drive memory response, check outputs mid-cycle, advance the model
  task automatic cycle();
    bit rsp, redir, exp_req, exp_deq, acc;
    int pre;
    req_t e;
    rsp = pend.size() > 0 && pend[0].due <= cyc && $urandom_range(0, 99) < rsp_pct;
    imem_rsp_valid = rsp;
    imem_rsp_data = rsp ? word_at(pend[0].addr) : $urandom();
    @(negedge clk);
    redir = redirect_valid && m_state != 2;
    exp_req = m_state == 0 && !redir && pend.size() < MAX_OUT && mq.size() + live_cnt() < QDEPTH;
    exp_deq = !redir && mq.size() > 0;
    chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
    if (exp_req) chk("req_addr", imem_req_addr, m_pc);
    chk("deq_valid", 32'(deq_valid), 32'(exp_deq));
    if (exp_deq) begin
      chk("deq_pc", deq_pc, mq[0]);
      chk("deq_inst", deq_inst, word_at(mq[0]));
    end
    chk("halted", 32'(halted), 32'(m_state == 2));
    acc = exp_req && imem_req_ready;
    if (acc) begin acc_log.push_back(m_pc); acc_cyc.push_back(cyc); end
    if (exp_deq && deq_ready) begin deq_log.push_back(mq[0]); deq_cyc.push_back(cyc); end
    if (halted && halted_cyc < 0) halted_cyc = cyc;
    pre = m_state;
    if (m_state == 0 && halt_req) m_state = 1;
    if (exp_deq && deq_ready) void'(mq.pop_front());
    if (rsp) begin
      e = pend.pop_front();
      if (!redir && e.live) mq.push_back(e.addr);
    end
    if (redir) begin
      mq.delete();
      foreach (pend[i]) pend[i].live = 0;
      m_pc = {redirect_addr[31:2], 2'b00};
    end
    if (acc) begin
      pend.push_back('{m_pc, cyc + lat, 1'b1});
      m_pc += 4;
    end
    if (pre == 1 && pend.size() == 0 && mq.size() == 0) m_state = 2;
    @(posedge clk);
    #1 cyc++;
  endtask

  task automatic rnd(input bit allow_redir);
    imem_req_ready = $urandom_range(0, 3) != 0;
    deq_ready = $urandom_range(0, 3) != 0;
    lat = $urandom_range(1, 4);
    redirect_valid = allow_redir && $urandom_range(0, 24) == 0;
    redirect_addr = $urandom_range(0, 3) == 0 ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom());
  endtask

  initial begin
    int n;
    logic [31:0] pc_before;
    errors = 0; checks = 0; cyc = 0;
    lat = 1; rsp_pct = 100;
    imem_req_ready = 1; deq_ready = 1; redirect_addr = 0;

    // basic streaming with a 1-cycle memory
    do_reset();
    repeat (8) cycle();
    chk("t1_n_acc", 32'(acc_log.size() >= 3), 1);
    chk("t1_addr0", acc_log[0], 32'h0);
    chk("t1_addr1", acc_log[1], 32'h4);
    chk("t1_addr2", acc_log[2], 32'h8);
    chk("t1_consecutive", 32'(acc_cyc[2] - acc_cyc[0]), 2);
    chk("t1_first_deq_pc", deq_log[0], 32'h0);
    chk("t1_deq_latency", 32'(deq_cyc[0] - acc_cyc[0]), 2);

    // consumer stalled: queue fills to QDEPTH and fetch stops
    do_reset();
    deq_ready = 0;
    repeat (12) cycle();
    chk("t2_accepted", 32'(acc_log.size()), 4);
    chk("t2_req_stalled", 32'(imem_req_valid), 0);
    chk("t2_head_valid", 32'(deq_valid), 1);
    chk("t2_head_pc", deq_pc, 32'h0);
    deq_ready = 1;
    repeat (6) cycle();
    chk("t2_resumed", 32'(acc_log.size() > 4), 1);

    // redirect with two stale requests in flight
    do_reset();
    lat = 3;
    repeat (2) cycle();
    redirect_valid = 1; redirect_addr = 32'h103;
    cycle();
    redirect_valid = 0;
    clear_logs();
    repeat (12) cycle();
    chk("t3_next_req", acc_log[0], 32'h100);
    chk("t3_first_deq", deq_log[0], 32'h100);
    chk("t3_second_deq", deq_log[1], 32'h104);

    // PC wraps at the top of the address space
    lat = 1;
    redirect_valid = 1; redirect_addr = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 0;
    clear_logs();
    repeat (8) cycle();
    chk("t4_req_top", acc_log[0], 32'hFFFF_FFFC);
    chk("t4_req_wrap", acc_log[1], 32'h0);
    chk("t4_deq_wrap", deq_log[1], 32'h0);

    // halt with 2 outstanding and 1 queued
    do_reset();
    rsp_pct = 80;
    n = 0;
    while (!(pend.size() == 2 && mq.size() == 1) && n < 500) begin
      rnd(0);
      cycle();
      n++;
    end
    chk("t5_setup_reached", 32'(n < 500), 1);
    rsp_pct = 100; lat = 1; imem_req_ready = 1; deq_ready = 0; halt_req = 1;
    clear_logs();
    repeat (4) cycle();
    deq_ready = 1;
    n = 0;
    while (!halted && n < 50) begin
      cycle();
      n++;
    end
    cycle();
    chk("t5_halted", 32'(halted), 1);
    chk("t5_no_new_req", 32'(acc_log.size()), 0);
    chk("t5_drained", 32'(deq_log.size()), 3);
    chk("t5_halt_latency", 32'(halted_cyc - deq_cyc[$]), 1);
    pc_before = imem_req_addr;
    halt_req = 0;
    redirect_valid = 1; redirect_addr = 32'h200;
    cycle();
    redirect_valid = 0;
    cycle();
    chk("t5_redirect_ignored", imem_req_addr, pc_before);
    chk("t5_sticky", 32'(halted), 1);

    // long random run with redirects, stalls and variable latency
    do_reset();
    rsp_pct = 75;
    repeat (3000) begin
      rnd(1);
      cycle();
    end

    // asynchronous reset in the middle of activity
    redirect_valid = 0;
    #2;
    do_reset();
    rsp_pct = 100; lat = 1; imem_req_ready = 1; deq_ready = 1;
    repeat (4) cycle();
    chk("t6_restart_pc", acc_log[0], PC_RESET);
    chk("t6_restart_deq", deq_log[0], PC_RESET);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
